// File: rtl/sysid_check_master_if.sv
// Avalon-MM read channel between the sysid check master and the system-ID slave.
interface sysid_check_master_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_check_master.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) and flags whether both
// match the values this hardware build expects.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1459711255,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  localparam bit          NO_LAT     = (READ_LATENCY == 0);
  localparam logic [2:0]  LAT_LAST   = NO_LAT ? 3'd0 : 3'(READ_LATENCY - 1);
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] stall_cnt;
  logic [2:0]  lat_cnt;
  logic        auto_pending;
  logic        launch, cap_id, cap_ts, abort;
  logic        lat_done, stalled_out;

  assign lat_done    = (lat_cnt == LAT_LAST);
  assign stalled_out = (stall_cnt == STALL_LAST);
  assign busy        = (state != IDLE) && (state != FIN);

  always_comb begin
    // NOTE: every output of this block gets a default here so no path leaves a latch.
    state_next  = state;
    launch      = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    abort       = 1'b0;
    avm.read    = 1'b0;
    avm.address = 1'b0;
    case (state)
      IDLE: if (start || auto_pending) begin
        launch     = 1'b1;
        state_next = RD_ID;
      end
      RD_ID: begin
        avm.read = 1'b1;
        if (!avm.waitrequest) begin
          cap_id     = NO_LAT;
          state_next = NO_LAT ? RD_TS : LAT_ID;
        end else if (stalled_out) begin
          abort      = 1'b1;
          state_next = FIN;
        end
      end
      LAT_ID: if (lat_done) begin
        cap_id     = 1'b1;
        state_next = RD_TS;
      end
      RD_TS: begin
        avm.read    = 1'b1;
        avm.address = 1'b1;
        if (!avm.waitrequest) begin
          cap_ts     = NO_LAT;
          state_next = NO_LAT ? FIN : LAT_TS;
        end else if (stalled_out) begin
          abort      = 1'b1;
          state_next = FIN;
        end
      end
      LAT_TS: begin
        avm.address = 1'b1;
        if (lat_done) begin
          cap_ts     = 1'b1;
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Result flags are registered on the edge that enters FIN so they are
  // already visible during the FIN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pending <= AUTO_START;
      stall_cnt    <= '0;
      lat_cnt      <= '0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
    end else begin
      auto_pending <= 1'b0;
      stall_cnt    <= (avm.read && avm.waitrequest) ? stall_cnt + 16'd1 : 16'd0;
      if ((state == LAT_ID || state == LAT_TS) && !lat_done) lat_cnt <= lat_cnt + 3'd1;
      else                                                   lat_cnt <= '0;
      if (launch) begin
        done    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if (cap_id) id_value <= avm.readdata;
      if (cap_ts) begin
        ts_value <= avm.readdata;
        done     <= 1'b1;
        id_ok    <= (id_value == EXPECTED_ID);
        ts_ok    <= (avm.readdata == EXPECTED_TS);
      end
      if (abort) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench: three sysid_check_master instances cover zero-wait/stall,
// timeout, and read-latency/mid-operation reset behaviour.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_TS  = 32'd1459711255;
  localparam logic [31:0] GARBAGE = 32'hDEADBEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: defaults, zero-latency slave ----------------
  logic        rst_a, start_a, wr_a;
  logic [31:0] id_word_a, ts_word_a;
  logic        busy_a, done_a, id_ok_a, ts_ok_a, timeout_a;
  logic [31:0] id_value_a, ts_value_a;
  sysid_check_master_if avm_a ();
  assign avm_a.waitrequest = wr_a;
  assign avm_a.readdata    = avm_a.address ? ts_word_a : id_word_a;

  sysid_check_master dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .avm(avm_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
    .timeout(timeout_a), .id_value(id_value_a), .ts_value(ts_value_a));

  // ---------------- instance B: short timeout, no auto start ----------------
  logic        rst_b, start_b, wr_b;
  logic        busy_b, done_b, id_ok_b, ts_ok_b, timeout_b;
  logic [31:0] id_value_b, ts_value_b;
  sysid_check_master_if avm_b ();
  assign avm_b.waitrequest = wr_b;
  assign avm_b.readdata    = 32'hCAFEF00D;

  sysid_check_master #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .avm(avm_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
    .timeout(timeout_b), .id_value(id_value_b), .ts_value(ts_value_b));

  // ---------------- instance C: two-cycle read latency ----------------------
  logic        rst_c, start_c;
  logic        busy_c, done_c, id_ok_c, ts_ok_c, timeout_c;
  logic [31:0] id_value_c, ts_value_c;
  logic [1:0]  vld_c = 2'b00;
  logic [1:0]  adr_c = 2'b00;
  sysid_check_master_if avm_c ();
  assign avm_c.waitrequest = 1'b0;
  // Slave model: data valid exactly two cycles after the accepting edge, garbage otherwise.
  always @(posedge clock) begin
    vld_c <= {vld_c[0], avm_c.read & ~avm_c.waitrequest};
    adr_c <= {adr_c[0], avm_c.address};
  end
  assign avm_c.readdata = vld_c[1] ? (adr_c[1] ? EXP_TS : 32'd0) : GARBAGE;

  sysid_check_master #(.READ_LATENCY(2), .AUTO_START(1'b0)) dut_c (
    .clock(clock), .reset(rst_c), .start(start_c), .avm(avm_c),
    .busy(busy_c), .done(done_c), .id_ok(id_ok_c), .ts_ok(ts_ok_c),
    .timeout(timeout_c), .id_value(id_value_c), .ts_value(ts_value_c));

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    wr_a = 1'b0; wr_b = 1'b1;
    id_word_a = 32'd0; ts_word_a = EXP_TS;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_read",    avm_a.read, 0);
    check("rst_busy",    busy_a,     0);
    check("rst_done",    done_a,     0);
    check("rst_id_ok",   id_ok_a,    0);
    check("rst_ts_val",  ts_value_a, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Auto start after reset release
    @(negedge clock);
    check("auto_rd0_read", avm_a.read,    1);
    check("auto_rd0_addr", avm_a.address, 0);
    check("auto_rd0_busy", busy_a,        1);
    check("noauto_b_busy", busy_b,        0);
    @(negedge clock);
    check("auto_rd1_read", avm_a.read,    1);
    check("auto_rd1_addr", avm_a.address, 1);
    @(negedge clock);
    check("auto_done",    done_a,     1);
    check("auto_id_ok",   id_ok_a,    1);
    check("auto_ts_ok",   ts_ok_a,    1);
    check("auto_timeout", timeout_a,  0);
    check("auto_busy",    busy_a,     0);
    check("auto_read",    avm_a.read, 0);
    check("auto_ts_val",  ts_value_a, EXP_TS);
    @(negedge clock);
    check("auto_done_hold", done_a, 1);

    // Timestamp mismatch
    ts_word_a = 32'h12345678;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("mis_busy",      busy_a, 1);
    check("mis_done_clr",  done_a, 0);
    repeat (2) @(negedge clock);
    check("mis_done",   done_a,     1);
    check("mis_ts_val", ts_value_a, 32'h12345678);
    check("mis_ts_ok",  ts_ok_a,    0);
    check("mis_id_ok",  id_ok_a,    1);
    start_a = 1'b1;  // lands in the FIN cycle and must be dropped
    @(negedge clock);
    start_a = 1'b0;
    check("fin_start_busy", busy_a, 0);
    check("fin_start_done", done_a, 1);

    // Five waitrequest stalls on the word 0 read
    ts_word_a = EXP_TS;
    wr_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_read", i), avm_a.read,    1);
      check($sformatf("stall%0d_addr", i), avm_a.address, 0);
      @(negedge clock);
    end
    check("stall_last_read", avm_a.read,    1);
    check("stall_last_addr", avm_a.address, 0);
    wr_a = 1'b0;
    @(negedge clock);
    check("stall_rd1_addr", avm_a.address, 1);
    check("stall_rd1_done", done_a,        0);
    @(negedge clock);
    check("stall_done",  done_a,  1);
    check("stall_id_ok", id_ok_a, 1);
    check("stall_ts_ok", ts_ok_a, 1);

    // Timeout with waitrequest stuck high
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_read%0d", i), avm_b.read, 1);
      @(negedge clock);
    end
    check("to_read_drop", avm_b.read,  0);
    check("to_timeout",   timeout_b,   1);
    check("to_done",      done_b,      1);
    check("to_busy",      busy_b,      0);
    check("to_id_ok",     id_ok_b,     0);
    check("to_ts_ok",     ts_ok_b,     0);
    check("to_id_val",    id_value_b,  0);

    // Read latency 2, start pulses while busy
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    check("lat_rd0_read", avm_c.read,    1);
    check("lat_rd0_addr", avm_c.address, 0);
    @(negedge clock);
    check("lat_l0_read", avm_c.read, 0);
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    @(negedge clock);
    check("lat_rd1_read", avm_c.read,    1);
    check("lat_rd1_addr", avm_c.address, 1);
    @(negedge clock);
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    check("lat_done_early", done_c, 0);
    @(negedge clock);
    check("lat_done",   done_c,     1);
    check("lat_id_ok",  id_ok_c,    1);
    check("lat_ts_ok",  ts_ok_c,    1);
    check("lat_ts_val", ts_value_c, EXP_TS);
    check("lat_id_val", id_value_c, 0);
    @(negedge clock);
    check("lat_no_requeue0", busy_c, 0);
    @(negedge clock);
    check("lat_no_requeue1", busy_c, 0);

    // Reset during LAT_TS, then a clean rerun
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    repeat (4) @(negedge clock);
    check("mr_in_lat_ts_addr", avm_c.address, 1);
    check("mr_in_lat_ts_busy", busy_c,        1);
    rst_c = 1'b1;
    @(negedge clock);
    check("mr_read",   avm_c.read, 0);
    check("mr_busy",   busy_c,     0);
    check("mr_done",   done_c,     0);
    check("mr_id_ok",  id_ok_c,    0);
    check("mr_ts_ok",  ts_ok_c,    0);
    check("mr_ts_val", ts_value_c, 0);
    rst_c = 1'b0;
    @(negedge clock);
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    repeat (6) @(negedge clock);
    check("mr2_done",   done_c,     1);
    check("mr2_id_ok",  id_ok_c,    1);
    check("mr2_ts_ok",  ts_ok_c,    1);
    check("mr2_ts_val", ts_value_c, EXP_TS);
    check("mr2_to",     timeout_c,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that interrogates the system-ID slave: reads word 0 (system ID) then word 1 (build timestamp), and compares both against expected values.
- Exposes pass/fail flags and the captured words to the Frogger top level (status LEDs / hex display), so a stale or mismatched software/hardware build is flagged at power-up.
- Handles slave waitrequest, a fixed read latency, and a bounded timeout.

Parameters:
- EXPECTED_ID, 32'd0, value expected at slave word 0.
- EXPECTED_TS, 32'd1459711255, value expected at slave word 1.
- READ_LATENCY, 0, fixed cycles from read acceptance to valid readdata (0..7).
- TIMEOUT_CYCLES, 255, maximum waitrequest-stalled cycles per read before abort (1..65535).
- AUTO_START, 1, 1 = run one check automatically in the first cycle after reset deasserts.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request to run a check; ignored while busy.
- avm_address, out, 1, word address to the sysid slave (0 = ID, 1 = timestamp).
- avm_read, out, 1, read strobe.
- avm_waitrequest, in, 1, slave stall; tie 0 for a zero-wait slave.
- avm_readdata, in, 32, slave read data.
- busy, out, 1, check in progress.
- done, out, 1, check finished; held until the next check starts.
- id_ok, out, 1, captured ID equals EXPECTED_ID.
- ts_ok, out, 1, captured timestamp equals EXPECTED_TS.
- timeout, out, 1, last check aborted on timeout.
- id_value, out, 32, captured word 0.
- ts_value, out, 32, captured word 1.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All registers update only on the rising edge of clock.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, state=IDLE, counters=0.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN.
- IDLE: a launch occurs on start=1, or on the first post-reset cycle when AUTO_START=1. On launch go to RD_ID and set busy=1. In the same edge clear done, id_ok, ts_ok and timeout.
- RD_ID: avm_read=1, avm_address=0.
  - A read is accepted on any edge where avm_read=1 and avm_waitrequest=0.
  - If READ_LATENCY=0, capture avm_readdata into id_value at the acceptance edge and go to RD_TS.
  - Otherwise drop avm_read and go to LAT_ID.
- LAT_ID: avm_read=0. Count READ_LATENCY edges after acceptance, capture avm_readdata on the last one, then go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with avm_address=1; the capture goes to ts_value. After capture go to FIN.
- FIN (one cycle):
  - id_ok = (id_value == EXPECTED_ID); ts_ok = (ts_value == EXPECTED_TS).
  - done=1, busy=0, return to IDLE.
  - done, id_ok and ts_ok hold until the next launch.
- avm_address and avm_read are held stable while avm_waitrequest=1.
- Timeout:
  - A 16-bit stall counter resets to 0 on entry to each RD state and increments on every edge with avm_waitrequest=1 in that state.
  - When it reaches TIMEOUT_CYCLES, drop avm_read and go to FIN with timeout=1, id_ok=0 and ts_ok=0 (forced, no compare).
  - id_value and ts_value keep whatever was captured so far.
- Latency, zero-wait slave with READ_LATENCY=0 and start high in cycle n:
  - avm_read=1 with addr 0 in cycle n+1, addr 1 in cycle n+2.
  - done=1 from cycle n+3.
  - In general the total is 3 + 2*READ_LATENCY + stall cycles.
- start while busy=1 is ignored and not queued. start in the same cycle FIN is active is also ignored.
- Reset mid-operation: at the reset edge all outputs return to reset values and avm_read drops immediately. No partial result is retained.
- Comparison is a full 32-bit equality. No masking, no sign interpretation.

Test Plan:
- Reset release, AUTO_START=1, slave returns 0 / 1459711255 with zero wait → read at addr 0 then addr 1 on consecutive cycles; done=1, id_ok=1, ts_ok=1, timeout=0 by the 3rd cycle after reset release.
- start pulse with the slave returning ts=0x12345678 → ts_value=0x12345678, ts_ok=0, id_ok=1, done=1.
- avm_waitrequest held high 5 cycles on the addr 0 read → avm_read/avm_address stable for those 5 cycles; data captured on the 6th edge; pass result; done 5 cycles later than the zero-wait case.
- TIMEOUT_CYCLES=8, waitrequest stuck high → avm_read drops after 8 stalled edges; timeout=1, id_ok=ts_ok=0, done=1, busy=0.
- READ_LATENCY=2, slave presents data 2 cycles after acceptance with garbage before → correct capture; done at cycle n+7; start pulses while busy produce no second sequence.
- Assert reset during LAT_TS → all outputs zero next cycle; a subsequent start runs a clean check with the correct result.
